// File: rtl/dc_ipu_filter_phase_gen.sv
// Per-line source-phase generator for the cubic scaler: steps a fixed-point source
// position per output pixel and emits the fractional phase plus four clamped tap indices.
module dc_ipu_filter_phase_gen #(
    parameter int unsigned COORD_WIDTH        = 12,
    parameter int unsigned STEP_FRACT_WIDTH   = 16,
    parameter int unsigned WEIGHT_WIDTH       = 10,
    parameter int unsigned WEIGHT_FRACT_WIDTH = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic                                     abort,
    input  logic [COORD_WIDTH-1:0]                   src_len,
    input  logic [COORD_WIDTH-1:0]                   dst_len,
    input  logic [COORD_WIDTH+STEP_FRACT_WIDTH-1:0]  step,
    input  logic [COORD_WIDTH+STEP_FRACT_WIDTH-1:0]  offset,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [WEIGHT_WIDTH-1:0]                  out_alpha,
    output logic [3:0][COORD_WIDTH-1:0]              out_taps,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     done
);

    localparam int unsigned PosWidth = COORD_WIDTH + 1 + STEP_FRACT_WIDTH;
    localparam int unsigned SWidth   = COORD_WIDTH + 3;

    typedef enum logic {StIdle, StRun} state_t;

    state_t                                state_q;
    logic [PosWidth-1:0]                   pos_q;
    logic [COORD_WIDTH-1:0]                cnt_q;
    logic [COORD_WIDTH-1:0]                src_len_q;
    logic [COORD_WIDTH-1:0]                dst_len_q;
    logic [COORD_WIDTH+STEP_FRACT_WIDTH-1:0] step_q;

    logic [PosWidth:0]                     pos_sum;
    logic [PosWidth-1:0]                   pos_step;
    logic [PosWidth-1:0]                   pos_start;
    logic                                  is_last;

    function automatic logic [WEIGHT_WIDTH-1:0] calc_alpha(input logic [PosWidth-1:0] p);
        return WEIGHT_WIDTH'(p[STEP_FRACT_WIDTH-1 -: WEIGHT_FRACT_WIDTH]);
    endfunction

    // Signed clamp so idx-1 below zero and idx+2 beyond the line both fold onto the edge.
    function automatic logic [3:0][COORD_WIDTH-1:0] calc_taps(input logic [PosWidth-1:0] p,
                                                               input logic [COORD_WIDTH-1:0] len);
        logic [COORD_WIDTH:0]     idx;
        logic signed [SWidth-1:0] base;
        logic signed [SWidth-1:0] hi;
        logic signed [SWidth-1:0] t;
        logic [3:0][COORD_WIDTH-1:0] res;
        idx  = p[PosWidth-1:STEP_FRACT_WIDTH];
        base = $signed({2'b00, idx}) - $signed(SWidth'(1));
        hi   = $signed({3'b000, len}) - $signed(SWidth'(1));
        for (int k = 0; k < 4; k++) begin
            t = base + $signed(SWidth'(k));
            if (t < $signed(SWidth'(0))) begin
                t = '0;
            end else if (t > hi) begin
                t = hi;
            end
            res[k] = t[COORD_WIDTH-1:0];
        end
        return res;
    endfunction

    always_comb begin
        pos_sum   = {1'b0, pos_q} + (PosWidth + 1)'(step_q);
        pos_step  = pos_sum[PosWidth] ? '1 : pos_sum[PosWidth-1:0];
        pos_start = {1'b0, offset};
        is_last   = (cnt_q == dst_len_q - COORD_WIDTH'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pos_q     <= '0;
            cnt_q     <= '0;
            src_len_q <= '0;
            dst_len_q <= '0;
            step_q    <= '0;
            out_valid <= 1'b0;
            out_alpha <= '0;
            out_taps  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (dst_len != '0) begin
                            state_q   <= StRun;
                            src_len_q <= src_len;
                            dst_len_q <= dst_len;
                            step_q    <= step;
                            pos_q     <= pos_start;
                            cnt_q     <= '0;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            out_alpha <= calc_alpha(pos_start);
                            out_taps  <= calc_taps(pos_start, src_len);
                            out_last  <= (dst_len == COORD_WIDTH'(1));
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    // Abort takes priority over a coincident final handshake: no done.
                    if (abort) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        out_last  <= 1'b0;
                    end else if (out_ready) begin
                        if (is_last) begin
                            state_q   <= StIdle;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cnt_q     <= cnt_q + COORD_WIDTH'(1);
                            pos_q     <= pos_step;
                            out_alpha <= calc_alpha(pos_step);
                            out_taps  <= calc_taps(pos_step, src_len_q);
                            out_last  <= (cnt_q + COORD_WIDTH'(1) == dst_len_q - COORD_WIDTH'(1));
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dc_ipu_filter_phase_gen.sv
// Scoreboard bench for dc_ipu_filter_phase_gen: a fixed-point model pushes expected
// samples per line and each accepted DUT sample is popped and compared.
module tb_dc_ipu_filter_phase_gen;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [11:0]       src_len = '0;
    logic [11:0]       dst_len = '0;
    logic [27:0]       step = '0;
    logic [27:0]       offset = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [9:0]        out_alpha;
    logic [3:0][11:0]  out_taps;
    logic              out_last;
    logic              busy;
    logic              done;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [9:0]       alpha;
        logic [3:0][11:0] taps;
        logic             last;
    } exp_t;

    exp_t exp_q[$];

    localparam longint PosMax = (64'sd1 <<< 29) - 1;

    dc_ipu_filter_phase_gen dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .src_len   (src_len),
        .dst_len   (dst_len),
        .step      (step),
        .offset    (offset),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_alpha (out_alpha),
        .out_taps  (out_taps),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int src, input longint pos, input bit last);
        exp_t   e;
        longint idx;
        longint t;
        idx     = pos >>> 16;
        e.alpha = 10'((pos >>> 8) & 255);
        for (int k = 0; k < 4; k++) begin
            t = idx - 1 + k;
            if (t < 0) t = 0;
            if (t > src - 1) t = src - 1;
            e.taps[k] = t[11:0];
        end
        e.last = last;
        return e;
    endfunction

    task automatic kick(input int src, input int dst, input longint stp, input longint off);
        longint pos;
        for (int i = 0; i < dst; i++) begin
            pos = off + i * stp;
            if (pos > PosMax) pos = PosMax;
            exp_q.push_back(model(src, pos, i == dst - 1));
        end
        @(negedge clk);
        src_len = 12'(src);
        dst_len = 12'(dst);
        step    = 28'(stp);
        offset  = 28'(off);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Accept samples until the scoreboard empties; optional stall and mid-line start poke.
    task automatic drain(input int stall_at, input int stall_len, input int poke_cyc,
                         output int done_cnt, output int last_cyc, output int done_cyc);
        exp_t e;
        exp_t snap;
        bit   have_snap = 0;
        int   popped = 0;
        int   stalled = 0;
        int   tail = 0;
        done_cnt = 0;
        last_cyc = -10;
        done_cyc = -10;
        for (int cyc = 0; cyc < 200; cyc++) begin
            start = (cyc == poke_cyc);
            if (cyc == poke_cyc) begin
                src_len = 12'd9;
                dst_len = 12'd2;
                step    = 28'h0123456;
                offset  = 28'h0050000;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            out_ready = 1'b1;
            if (out_valid) begin
                if (have_snap) begin
                    vectors++;
                    if ({out_alpha, out_taps, out_last} !== snap) begin
                        miscompares++;
                        $display("FAIL stall_hold: got %0h expected %0h",
                                 {out_alpha, out_taps, out_last}, snap);
                    end
                    have_snap = 0;
                end
                if (popped == stall_at && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                    snap = {out_alpha, out_taps, out_last};
                    have_snap = 1;
                end else if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_sample: got alpha %0d with no sample expected", out_alpha);
                end else begin
                    e = exp_q.pop_front();
                    vectors++;
                    if ({out_alpha, out_taps, out_last} !== e) begin
                        miscompares++;
                        $display("FAIL sample%0d: got alpha %0d taps %0d,%0d,%0d,%0d last %0b expected alpha %0d taps %0d,%0d,%0d,%0d last %0b",
                                 popped, out_alpha, out_taps[0], out_taps[1], out_taps[2],
                                 out_taps[3], out_last, e.alpha, e.taps[0], e.taps[1],
                                 e.taps[2], e.taps[3], e.last);
                    end
                    if (e.last) last_cyc = cyc;
                    popped++;
                end
            end
            if (exp_q.size() == 0) tail++;
            if (tail > 3) break;
            @(negedge clk);
        end
        start = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d samples left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_line_end(input string name, input int dc, input int lc, input int dcy);
        vectors++;
        if (dc != 1) begin
            miscompares++;
            $display("FAIL %s_done_count: got %0d expected 1", name, dc);
        end
        vectors++;
        if (dcy != lc + 1) begin
            miscompares++;
            $display("FAIL %s_done_timing: got cycle %0d expected %0d", name, dcy, lc + 1);
        end
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle_after: got busy %0b valid %0b expected 0 0", name, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({out_valid, out_alpha, out_taps, out_last, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got %0h expected 0",
                     {out_valid, out_alpha, out_taps, out_last, busy, done});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_upscale();
        int dc, lc, dcy;
        kick(4, 8, 64'h8000, 0);
        vectors++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL upscale_latency: got valid %0b busy %0b expected 1 1", out_valid, busy);
        end
        vectors++;
        if (out_taps !== {12'd2, 12'd1, 12'd0, 12'd0}) begin
            miscompares++;
            $display("FAIL upscale_first_taps: got %0h expected 0,0,1,2", out_taps);
        end
        drain(-1, 0, -1, dc, lc, dcy);
        check_line_end("upscale", dc, lc, dcy);
    endtask

    task automatic test_downscale();
        int dc, lc, dcy;
        kick(16, 4, 64'h40000, 64'h18000);
        drain(-1, 0, -1, dc, lc, dcy);
        check_line_end("downscale", dc, lc, dcy);
    endtask

    task automatic test_backpressure();
        int dc, lc, dcy;
        kick(4, 8, 64'h8000, 0);
        drain(2, 3, -1, dc, lc, dcy);
        check_line_end("backpressure", dc, lc, dcy);
    endtask

    task automatic test_zero_len();
        int dcount = 0;
        int first = -1;
        kick(4, 0, 64'h8000, 0);
        for (int c = 0; c < 5; c++) begin
            if (done) begin
                dcount++;
                if (first < 0) first = c;
            end
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_len_quiet: got valid %0b busy %0b expected 0 0", out_valid, busy);
            end
            @(negedge clk);
        end
        vectors++;
        if (dcount != 1 || first != 0) begin
            miscompares++;
            $display("FAIL zero_len_done: got count %0d at %0d expected 1 at 0", dcount, first);
        end
    endtask

    task automatic test_abort_reset();
        exp_t e;
        int   dcount = 0;
        int   dc, lc, dcy;
        kick(4, 8, 64'h8000, 0);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if ({out_alpha, out_taps, out_last} !== e) begin
                miscompares++;
                $display("FAIL abort_pre%0d: got %0h expected %0h", i,
                         {out_alpha, out_taps, out_last}, e);
            end
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_q.delete();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_drop: got valid %0b busy %0b expected 0 0", out_valid, busy);
        end
        for (int c = 0; c < 4; c++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        // Mid-line asynchronous reset, applied away from the clock edge.
        kick(4, 8, 64'h8000, 64'h14000);
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({out_valid, out_alpha, out_taps, out_last, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_line: got %0h expected 0",
                     {out_valid, out_alpha, out_taps, out_last, busy, done});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        vectors++;
        if (dcount != 0) begin
            miscompares++;
            $display("FAIL abort_reset_no_done: got %0d expected 0", dcount);
        end
        kick(4, 8, 64'h8000, 0);
        drain(-1, 0, -1, dc, lc, dcy);
        check_line_end("restart", dc, lc, dcy);
    endtask

    task automatic test_start_busy_clamp();
        int dc, lc, dcy;
        kick(4, 8, 64'h8000, 0);
        drain(-1, 0, 3, dc, lc, dcy);
        check_line_end("start_busy", dc, lc, dcy);
        kick(1, 4, 64'h6000, 64'h3000);
        drain(-1, 0, -1, dc, lc, dcy);
        check_line_end("src_len1", dc, lc, dcy);
        kick(5, 3, 64'h10000, 64'h80000);
        vectors++;
        if (out_taps !== {12'd4, 12'd4, 12'd4, 12'd4}) begin
            miscompares++;
            $display("FAIL beyond_edge_taps: got %0h expected 4,4,4,4", out_taps);
        end
        drain(-1, 0, -1, dc, lc, dcy);
        check_line_end("beyond_edge", dc, lc, dcy);
        kick(16, 3, 64'hFFFFFFF, 64'hFFFFFFF);
        drain(-1, 0, -1, dc, lc, dcy);
        check_line_end("saturate", dc, lc, dcy);
    endtask

    initial begin
        test_reset();
        test_upscale();
        test_downscale();
        test_backpressure();
        test_zero_len();
        test_abort_reset();
        test_start_busy_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dc_ipu_filter_phase_gen.md
Name: dc_ipu_filter_phase_gen

Overview:
Per-line source-phase generator for the IPU cubic scaler, upstream of the cubic weight stage. For each output pixel of a line it steps a fixed-point source position. It emits the fractional phase (alpha, in weight format) and the four clamped source tap indices that the 4-tap filter needs. A valid/ready handshake lets the downstream weight/filter pipeline stall it.

Parameters:
COORD_WIDTH, 12, width of pixel counts and indices.
STEP_FRACT_WIDTH, 16, fractional bits of step, offset and the position accumulator.
WEIGHT_WIDTH, 10, signed alpha output width. Must be >= WEIGHT_FRACT_WIDTH+2.
WEIGHT_FRACT_WIDTH, 8, fractional bits of alpha. Must be <= STEP_FRACT_WIDTH.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin a line; sampled only in IDLE
abort  in  1  synchronous line cancel
src_len  in  COORD_WIDTH  source pixels in the line (>=1)
dst_len  in  COORD_WIDTH  output pixels to generate (0 allowed)
step  in  COORD_WIDTH+STEP_FRACT_WIDTH  unsigned source increment per output pixel
offset  in  COORD_WIDTH+STEP_FRACT_WIDTH  unsigned initial source position
out_valid  out  1  sample valid
out_ready  in  1  downstream accepts
out_alpha  out  WEIGHT_WIDTH  signed phase, always in [0,1)
out_taps  out  4 x COORD_WIDTH  source indices for taps 0..3
out_last  out  1  marks the final sample of the line
busy  out  1  line in progress
done  out  1  one-cycle pulse at line completion

Behaviour:
- Reset values: out_valid=0, out_alpha=0, out_taps all 0, out_last=0, busy=0, done=0. FSM goes to IDLE.
- FSM states are IDLE and RUN.
- IDLE:
  - On start with dst_len!=0: latch src_len, dst_len and step; set pos<=offset and cnt<=0; go to RUN.
  - On start with dst_len==0: stay in IDLE and pulse done on the next cycle. No samples are produced.
- RUN:
  - busy=1 and out_valid=1.
  - Handshake = out_valid & out_ready.
  - On handshake when cnt==dst_len-1: go to IDLE and pulse done on the next cycle.
  - On any other handshake: cnt<=cnt+1 and pos<=pos+step.
- All outputs are driven from registered state. There is no combinational path from any input to any output.
- Latency: start in cycle N gives the first sample valid in cycle N+1. With out_ready held high, the block delivers one sample per cycle.
- Stall: while out_valid & !out_ready, out_alpha, out_taps and out_last hold stable.
- start is ignored while busy. Config input changes are ignored outside the IDLE start cycle.
- abort in RUN: go to IDLE next cycle, out_valid drops, no done pulse. If abort coincides with a handshake, abort wins and no done pulse is issued. abort in IDLE has no effect.
- Position accumulator pos is unsigned, COORD_WIDTH+1+STEP_FRACT_WIDTH bits. On overflow it saturates at all-ones.
- idx = pos integer part.
- out_alpha = {0, pos[STEP_FRACT_WIDTH-1 -: WEIGHT_FRACT_WIDTH]}, zero-extended. The discarded low bits are truncated, not rounded.
- out_taps[k] = clamp(idx-1+k, 0, src_len-1) for k=0..3. The clamp is computed signed, on at least COORD_WIDTH+2 bits.
- If idx >= src_len, all taps are src_len-1; alpha is unchanged.
- out_last = out_valid & (cnt==dst_len-1).
- Reset asserted mid-line returns the block to the reset values immediately, with no done pulse.

Test Plan:
- Upscale 2x: src_len=4, dst_len=8, step=0x8000, offset=0, ready=1. Required:
  - alpha sequence 0,128,0,128,...
  - idx sequence 0,0,1,1,2,2,3,3
  - taps of the first sample 0,0,1,2; taps of the last sample 2,3,3,3
  - out_last only on sample 7, done in the cycle after it.
- Downscale: src_len=16, dst_len=4, step=0x40000, offset=0x18000. Required: idx 1,5,9,13 with alpha=128 on every sample; taps of the last sample 12,13,14,15.
- Backpressure: upscale case with ready low for 3 cycles on sample 2. Required: outputs held for 3 cycles, then the sequence continues with no skipped or duplicated sample.
- dst_len=0 start: out_valid never rises; done pulses exactly once, one cycle after start; busy stays 0.
- Abort and reset: abort during sample 3 gives out_valid=0 next cycle and no done. A reset pulse during a separate line gives all outputs 0 immediately. A fresh start afterwards runs correctly from sample 0.
- Start while busy and edge clamp:
  - start pulsed mid-line has no effect.
  - With src_len=1, every tap is 0.
  - With offset beyond src_len, every tap is src_len-1.
